// File: rtl/game_seq_ctl_if.sv
// Signal bundle between the pong match sequencer and the rest of the game top level.
// The slave side is the sequencer; the master side drives the frame, input and miss events.
interface game_seq_ctl_if;
    logic       vsync_in;
    logic       button;
    logic       mouse_left;
    logic       miss_p1;
    logic       miss_p2;
    logic       ball_run;
    logic       ball_hold;
    logic       serve_dir;
    logic [1:0] score_p1;
    logic [1:0] score_p2;
    logic [1:0] winner;
    logic       blink;
    logic [2:0] state_out;

    modport slave (
        input  vsync_in, button, mouse_left, miss_p1, miss_p2,
        output ball_run, ball_hold, serve_dir, score_p1, score_p2, winner, blink, state_out
    );

    modport master (
        output vsync_in, button, mouse_left, miss_p1, miss_p2,
        input  ball_run, ball_hold, serve_dir, score_p1, score_p2, winner, blink, state_out
    );
endinterface

// File: rtl/game_seq_ctl.sv
// Pong match sequencer: serve/play/point-delay/game-over flow, score counters and winner flag.
// Delays are counted in frames, one per vsync rising edge.
//
// state | meaning
// IDLE  | waiting for start button, scores forced to 0
// SERVE | ball held at centre, waiting for mouse_left serve
// PLAY  | ball moving, miss pulses score points
// POINT | ball held for POINT_DELAY_FRAMES frames before re-serve
// OVER  | match decided, blink toggles, button restarts
module game_seq_ctl #(
    parameter int WIN_SCORE          = 3,
    parameter int POINT_DELAY_FRAMES = 60,
    parameter int BLINK_FRAMES       = 16
) (
    input  logic           clk,
    input  logic           rst,
    game_seq_ctl_if.slave  bus
);

    localparam int MAX_FRAMES = (POINT_DELAY_FRAMES > BLINK_FRAMES) ? POINT_DELAY_FRAMES
                                                                     : BLINK_FRAMES;
    localparam int CNT_W = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [1:0]       WIN        = 2'(WIN_SCORE);
    localparam logic [1:0]       SCORE_MAX  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic             button_q;
    logic             mouse_q;
    logic             vsync_q;

    logic             ball_run;
    logic             ball_hold;
    logic             serve_dir;
    logic [1:0]       score_p1;
    logic [1:0]       score_p2;
    logic [1:0]       winner;
    logic             blink;

    logic             button_edge;
    logic             mouse_edge;
    logic             vsync_edge;
    logic [1:0]       score_p1_inc;
    logic [1:0]       score_p2_inc;

    assign button_edge = bus.button     & ~button_q;
    assign mouse_edge  = bus.mouse_left & ~mouse_q;
    assign vsync_edge  = bus.vsync_in   & ~vsync_q;

    // Saturating increments; scores never wrap past 3.
    assign score_p1_inc = (score_p1 == SCORE_MAX) ? SCORE_MAX : score_p1 + 2'd1;
    assign score_p2_inc = (score_p2 == SCORE_MAX) ? SCORE_MAX : score_p2 + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            button_q  <= 1'b0;
            mouse_q   <= 1'b0;
            vsync_q   <= 1'b0;
            ball_run  <= 1'b0;
            ball_hold <= 1'b1;
            serve_dir <= 1'b0;
            score_p1  <= 2'd0;
            score_p2  <= 2'd0;
            winner    <= 2'b00;
            blink     <= 1'b0;
        end else begin
            button_q <= bus.button;
            mouse_q  <= bus.mouse_left;
            vsync_q  <= bus.vsync_in;

            case (state)
                IDLE: begin
                    ball_run  <= 1'b0;
                    ball_hold <= 1'b1;
                    score_p1  <= 2'd0;
                    score_p2  <= 2'd0;
                    winner    <= 2'b00;
                    blink     <= 1'b0;
                    frame_cnt <= '0;
                    if (button_edge) begin
                        state     <= SERVE;
                        serve_dir <= 1'b0;
                    end
                end

                SERVE: begin
                    ball_run  <= 1'b0;
                    ball_hold <= 1'b1;
                    if (mouse_edge) begin
                        state     <= PLAY;
                        ball_run  <= 1'b1;
                        ball_hold <= 1'b0;
                    end
                end

                PLAY: begin
                    ball_run  <= 1'b1;
                    ball_hold <= 1'b0;
                    if (bus.miss_p1 && bus.miss_p2) begin
                        // Both sides missed together: replay the point, nobody scores.
                        state     <= POINT;
                        frame_cnt <= '0;
                        ball_run  <= 1'b0;
                        ball_hold <= 1'b1;
                    end else if (bus.miss_p1) begin
                        score_p2  <= score_p2_inc;
                        serve_dir <= 1'b1;
                        frame_cnt <= '0;
                        ball_run  <= 1'b0;
                        ball_hold <= 1'b1;
                        if (score_p2_inc == WIN) begin
                            state  <= OVER;
                            winner <= 2'b10;
                        end else begin
                            state <= POINT;
                        end
                    end else if (bus.miss_p2) begin
                        score_p1  <= score_p1_inc;
                        serve_dir <= 1'b0;
                        frame_cnt <= '0;
                        ball_run  <= 1'b0;
                        ball_hold <= 1'b1;
                        if (score_p1_inc == WIN) begin
                            state  <= OVER;
                            winner <= 2'b01;
                        end else begin
                            state <= POINT;
                        end
                    end
                end

                POINT: begin
                    ball_run  <= 1'b0;
                    ball_hold <= 1'b1;
                    if (vsync_edge) begin
                        if (frame_cnt == POINT_LAST) begin
                            state     <= SERVE;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                OVER: begin
                    ball_run  <= 1'b0;
                    ball_hold <= 1'b1;
                    if (button_edge) begin
                        state     <= SERVE;
                        serve_dir <= 1'b0;
                        score_p1  <= 2'd0;
                        score_p2  <= 2'd0;
                        winner    <= 2'b00;
                        blink     <= 1'b0;
                        frame_cnt <= '0;
                    end else if (vsync_edge) begin
                        if (frame_cnt == BLINK_LAST) begin
                            blink     <= ~blink;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    frame_cnt <= '0;
                    ball_run  <= 1'b0;
                    ball_hold <= 1'b1;
                    serve_dir <= 1'b0;
                    score_p1  <= 2'd0;
                    score_p2  <= 2'd0;
                    winner    <= 2'b00;
                    blink     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ball_run  = ball_run;
    assign bus.ball_hold = ball_hold;
    assign bus.serve_dir = serve_dir;
    assign bus.score_p1  = score_p1;
    assign bus.score_p2  = score_p2;
    assign bus.winner    = winner;
    assign bus.blink     = blink;
    assign bus.state_out = state;

endmodule

// File: tb/tb_game_seq_ctl.sv
// Bench for game_seq_ctl: directed scenarios plus a random event stream, all checked
// against an event-level model of the match rules.
module tb_game_seq_ctl;

    localparam int WIN = 3;
    localparam int PD  = 60;
    localparam int BF  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_seq_ctl_if bus();

    game_seq_ctl #(
        .WIN_SCORE(WIN),
        .POINT_DELAY_FRAMES(PD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Match model, advanced once per delivered event rather than per clock.
    int m_state, m_s1, m_s2, m_win, m_dir, m_blink, m_frames;

    function automatic void m_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_blink = 0; m_frames = 0;
    endfunction

    function automatic void m_button();
        if (m_state == 0 || m_state == 4) begin
            m_state = 1; m_dir = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_blink = 0; m_frames = 0;
        end
    endfunction

    function automatic void m_mouse();
        if (m_state == 1) m_state = 2;
    endfunction

    function automatic void m_miss(input bit a, input bit b);
        if (m_state != 2 || (!a && !b)) return;
        m_frames = 0;
        if (a && b) begin
            m_state = 3;
        end else if (a) begin
            m_s2  = (m_s2 < 3) ? m_s2 + 1 : 3;
            m_dir = 1;
            if (m_s2 == WIN) begin m_state = 4; m_win = 2; end
            else m_state = 3;
        end else begin
            m_s1  = (m_s1 < 3) ? m_s1 + 1 : 3;
            m_dir = 0;
            if (m_s1 == WIN) begin m_state = 4; m_win = 1; end
            else m_state = 3;
        end
    endfunction

    function automatic void m_vsync();
        if (m_state == 3) begin
            m_frames++;
            if (m_frames == PD) begin m_state = 1; m_frames = 0; end
        end else if (m_state == 4) begin
            m_frames++;
            if (m_frames == BF) begin m_blink = 1 - m_blink; m_frames = 0; end
        end
    endfunction

    // {state, run, hold, dir, score_p1, score_p2, winner, blink}
    function automatic logic [12:0] m_vec();
        return {3'(m_state), (m_state == 2), (m_state != 2), m_dir[0],
                2'(m_s1), 2'(m_s2), 2'(m_win), m_blink[0]};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.state_out, bus.ball_run, bus.ball_hold, bus.serve_dir,
                bus.score_p1, bus.score_p2, bus.winner, bus.blink};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_button();
        @(negedge clk);
        bus.button = 1'b1;
        m_button();
        tick($urandom_range(1, 3));
        bus.button = 1'b0;
        tick(1);
    endtask

    task automatic press_mouse();
        @(negedge clk);
        bus.mouse_left = 1'b1;
        m_mouse();
        tick($urandom_range(1, 3));
        bus.mouse_left = 1'b0;
        tick(1);
    endtask

    task automatic miss(input bit a, input bit b);
        @(negedge clk);
        bus.miss_p1 = a;
        bus.miss_p2 = b;
        m_miss(a, b);
        @(negedge clk);
        bus.miss_p1 = 1'b0;
        bus.miss_p2 = 1'b0;
    endtask

    task automatic vsync(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.vsync_in = 1'b1;
            m_vsync();
            tick(2);
            bus.vsync_in = 1'b0;
            tick(1);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        tick(n);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset(3);
        n_total++;
        if (dut_vec() !== 13'b000_0_1_0_00_00_00_0) begin
            $display("FAIL reset_values: got %b want %b", dut_vec(), 13'b000_0_1_0_00_00_00_0);
        end else n_pass++;
        press_mouse();
        miss(1'b1, 1'b0);
        tick(2);
        n_total++;
        if (dut_vec() !== m_vec()) begin
            $display("FAIL idle_ignores: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
    endtask

    task automatic test_start_serve();
        do_reset(1);
        @(negedge clk);
        bus.button = 1'b1;
        m_button();
        @(negedge clk);
        n_total++;
        if (bus.state_out !== 3'd1) begin
            $display("FAIL start_latency: state got %0d want 1", bus.state_out);
        end else n_pass++;
        tick(2);
        bus.button = 1'b0;
        tick(1);
        press_button();
        n_total++;
        if (dut_vec() !== m_vec()) begin
            $display("FAIL serve_ignores_button: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
        @(negedge clk);
        bus.mouse_left = 1'b1;
        m_mouse();
        @(negedge clk);
        n_total++;
        if (bus.state_out !== 3'd2 || bus.ball_run !== 1'b1 || bus.ball_hold !== 1'b0) begin
            $display("FAIL serve_to_play: state %0d run %b hold %b want 2 1 0",
                     bus.state_out, bus.ball_run, bus.ball_hold);
        end else n_pass++;
        tick(100);
        bus.mouse_left = 1'b0;
        tick(1);
        n_total++;
        if (dut_vec() !== m_vec()) begin
            $display("FAIL mouse_held: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
    endtask

    task automatic test_point_delay();
        miss(1'b0, 1'b1);
        n_total++;
        if (bus.score_p1 !== 2'd1 || bus.serve_dir !== 1'b0 || bus.state_out !== 3'd3) begin
            $display("FAIL point_entry: p1 %0d dir %b state %0d want 1 0 3",
                     bus.score_p1, bus.serve_dir, bus.state_out);
        end else n_pass++;
        press_mouse();
        press_button();
        miss(1'b1, 1'b0);
        vsync(PD - 1);
        n_total++;
        if (bus.state_out !== 3'd3 || dut_vec() !== m_vec()) begin
            $display("FAIL point_59: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
        vsync(1);
        n_total++;
        if (bus.state_out !== 3'd1 || dut_vec() !== m_vec()) begin
            $display("FAIL point_60: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
    endtask

    task automatic test_match_end();
        do_reset(2);
        press_button();
        for (int k = 1; k <= 3; k++) begin
            press_mouse();
            miss(1'b1, 1'b0);
            if (k < 3) begin
                vsync(PD);
                n_total++;
                if (bus.score_p2 !== 2'(k) || bus.state_out !== 3'd1 || bus.serve_dir !== 1'b1) begin
                    $display("FAIL match_point%0d: p2 %0d state %0d dir %b want %0d 1 1",
                             k, bus.score_p2, bus.state_out, bus.serve_dir, k);
                end else n_pass++;
            end
        end
        n_total++;
        if (bus.score_p2 !== 2'd3 || bus.winner !== 2'b10 || bus.state_out !== 3'd4) begin
            $display("FAIL match_over: p2 %0d winner %b state %0d want 3 10 4",
                     bus.score_p2, bus.winner, bus.state_out);
        end else n_pass++;
        vsync(BF - 1);
        n_total++;
        if (bus.blink !== 1'b0) begin
            $display("FAIL blink_15: got %b want 0", bus.blink);
        end else n_pass++;
        vsync(1);
        n_total++;
        if (bus.blink !== 1'b1) begin
            $display("FAIL blink_16: got %b want 1", bus.blink);
        end else n_pass++;
        vsync(BF);
        n_total++;
        if (bus.blink !== 1'b0 || dut_vec() !== m_vec()) begin
            $display("FAIL blink_32: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
        press_button();
        n_total++;
        if (dut_vec() !== 13'b001_0_1_0_00_00_00_0) begin
            $display("FAIL restart: got %b want %b", dut_vec(), 13'b001_0_1_0_00_00_00_0);
        end else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset(1);
        press_button();
        press_mouse();
        miss(1'b0, 1'b1);
        vsync(PD);
        press_mouse();
        miss(1'b1, 1'b0);
        vsync(PD);
        press_mouse();
        miss(1'b1, 1'b1);
        n_total++;
        if (bus.score_p1 !== 2'd1 || bus.score_p2 !== 2'd1 || bus.serve_dir !== 1'b1 ||
            bus.state_out !== 3'd3) begin
            $display("FAIL both_miss: got %b want p1=1 p2=1 dir=1 state=3", dut_vec());
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        press_button();
        press_mouse(); miss(1'b0, 1'b1); vsync(PD);
        press_mouse(); miss(1'b0, 1'b1); vsync(PD);
        press_mouse(); miss(1'b1, 1'b0);
        vsync(30);
        n_total++;
        if (bus.score_p1 !== 2'd2 || bus.score_p2 !== 2'd1 || bus.state_out !== 3'd3) begin
            $display("FAIL mid_setup: got %b want p1=2 p2=1 state=3", dut_vec());
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        bus.vsync_in = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.vsync_in = 1'b0;
        n_total++;
        if (dut_vec() !== 13'b000_0_1_0_00_00_00_0) begin
            $display("FAIL mid_reset: got %b want %b", dut_vec(), 13'b000_0_1_0_00_00_00_0);
        end else n_pass++;
        tick(1);
        press_button();
        press_mouse();
        miss(1'b0, 1'b1);
        vsync(PD - 1);
        n_total++;
        if (bus.state_out !== 3'd3) begin
            $display("FAIL mid_recount_59: state got %0d want 3", bus.state_out);
        end else n_pass++;
        vsync(1);
        n_total++;
        if (bus.state_out !== 3'd1 || dut_vec() !== m_vec()) begin
            $display("FAIL mid_recount_60: got %b want %b", dut_vec(), m_vec());
        end else n_pass++;
    endtask

    task automatic test_random();
        int r;
        do_reset(1);
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    press_button();
                2, 3:    press_mouse();
                4, 5:    miss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                6, 7, 8: vsync($urandom_range(1, 25));
                default: if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
                         else vsync(PD);
            endcase
            tick($urandom_range(0, 2));
            n_total++;
            if (dut_vec() !== m_vec()) begin
                $display("FAIL random_step%0d: got %b want %b", i, dut_vec(), m_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        bus.vsync_in   = 1'b0;
        bus.button     = 1'b0;
        bus.mouse_left = 1'b0;
        bus.miss_p1    = 1'b0;
        bus.miss_p2    = 1'b0;
        m_reset();
        test_reset();
        test_start_serve();
        test_point_delay();
        test_match_end();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
